// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in / parallel-out frame buffer:
// FSM state encoding and default geometry.
package sipo_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 32;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

endpackage : sipo_pkg

// File: rtl/sipo_shift_reg.sv
// Enable-gated sample shift register; slice 0 of q_flat is the newest sample,
// slice DEPTH-1 the oldest.
module sipo_shift_reg #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [DATA_W-1:0]       d_in,
    output logic [DEPTH*DATA_W-1:0] q_flat
);

    logic [DEPTH*DATA_W-1:0] q_q;

    // NOTE: this storage is reset explicitly so that data from an aborted
    // capture can never reappear in a later frame.
    if (DEPTH == 1) begin : g_single
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)  q_q <= '0;
            else if (en) q_q <= d_in;
        end
    end else begin : g_chain
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)  q_q <= '0;
            else if (en) q_q <= {q_q[(DEPTH-1)*DATA_W-1:0], d_in};
        end
    end

    assign q_flat = q_q;

endmodule : sipo_shift_reg

// File: rtl/sipo_frame_buf.sv
// Frame capture buffer: collects DEPTH samples, snapshots them into a held
// output frame with valid/ack handshake, single or continuous capture.
module sipo_frame_buf
    import sipo_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int DEPTH  = DEF_DEPTH,
    localparam int CNT_W  = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    mode_cont,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       d_in,
    output logic                    in_ready,
    output logic [DEPTH*DATA_W-1:0] frame_data,
    output logic                    frame_valid,
    input  logic                    frame_ack,
    output logic                    busy,
    output logic [CNT_W-1:0]        fill_count,
    output logic                    overrun
);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        fill_q, fill_d;
    logic                    mode_q, mode_d;
    logic                    fv_q, fv_d;
    logic                    ovr_q, ovr_d;
    logic [DEPTH*DATA_W-1:0] frame_q, frame_d;
    logic [(DEPTH-1)*DATA_W-1:0] hist;
    logic                    shift_en;
    logic                    accept;
    logic                    last;

    // History holds the DEPTH-1 newest samples; the sample being accepted
    // completes the frame, so the snapshot needs no extra cycle.
    sipo_shift_reg #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH-1)
    ) u_shift (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (shift_en),
        .d_in   (d_in),
        .q_flat (hist)
    );

    assign accept = (state_q == FILL) && in_valid;
    assign last   = accept && (fill_q == CNT_W'(DEPTH-1));

    // NOTE: every next-state signal gets its hold value first so no path
    // through this block can infer a latch.
    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        mode_d   = mode_q;
        fv_d     = fv_q;
        ovr_d    = ovr_q;
        frame_d  = frame_q;
        shift_en = 1'b0;

        if (fv_q && frame_ack) fv_d = 1'b0;

        if (start) begin
            // Restart wins over a completing sample: the partial frame is dropped.
            state_d = FILL;
            fill_d  = '0;
            mode_d  = mode_cont;
            ovr_d   = 1'b0;
        end else if (accept) begin
            shift_en = 1'b1;
            fill_d   = last ? '0 : fill_q + 1'b1;
            if (last) begin
                if (!fv_q || frame_ack) begin
                    frame_d = {hist, d_in};
                    fv_d    = 1'b1;
                end else begin
                    ovr_d   = 1'b1;
                end
                if (!mode_q) state_d = IDLE;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            fill_q  <= '0;
            mode_q  <= 1'b0;
            fv_q    <= 1'b0;
            ovr_q   <= 1'b0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            mode_q  <= mode_d;
            fv_q    <= fv_d;
            ovr_q   <= ovr_d;
            frame_q <= frame_d;
        end
    end

    assign in_ready    = (state_q == FILL);
    assign busy        = (state_q == FILL);
    assign fill_count  = fill_q;
    assign frame_valid = fv_q;
    assign frame_data  = frame_q;
    assign overrun     = ovr_q;

endmodule : sipo_frame_buf

// File: tb/tb_sipo_frame_buf.sv
// Directed bench for sipo_frame_buf: a DEPTH=4 instance for the handshake
// scenarios and a DEPTH=32 / DATA_W=12 instance for the wide frame.
module tb_sipo_frame_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, mode_cont, in_valid, frame_ack;
    logic [15:0] d_in;
    logic        in_ready, frame_valid, busy, overrun;
    logic [63:0] frame_data;
    logic [1:0]  fill_count;

    logic         b_start, b_mode, b_valid, b_ack;
    logic [11:0]  b_din;
    logic         b_ready, b_fv, b_busy, b_ovr;
    logic [383:0] b_frame;
    logic [4:0]   b_fill;

    int total = 0;
    int bad   = 0;
    logic [63:0]  exp64;
    logic [383:0] exp384;

    always #5 clk = ~clk;

    sipo_frame_buf #(.DATA_W(16), .DEPTH(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode_cont(mode_cont),
        .in_valid(in_valid), .d_in(d_in), .in_ready(in_ready),
        .frame_data(frame_data), .frame_valid(frame_valid), .frame_ack(frame_ack),
        .busy(busy), .fill_count(fill_count), .overrun(overrun)
    );

    sipo_frame_buf #(.DATA_W(12), .DEPTH(32)) u_big (
        .clk(clk), .rst_n(rst_n), .start(b_start), .mode_cont(b_mode),
        .in_valid(b_valid), .d_in(b_din), .in_ready(b_ready),
        .frame_data(b_frame), .frame_valid(b_fv), .frame_ack(b_ack),
        .busy(b_busy), .fill_count(b_fill), .overrun(b_ovr)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        start = 0; mode_cont = 0; in_valid = 0; frame_ack = 0; d_in = '0;
        b_start = 0; b_mode = 0; b_valid = 0; b_ack = 0; b_din = '0;
        repeat (2) tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic do_start(input logic m);
        start = 1'b1; mode_cont = m;
        tick;
        start = 1'b0; mode_cont = 1'b0;
    endtask

    task automatic feed(input logic [15:0] v);
        in_valid = 1'b1; d_in = v;
        tick;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        apply_reset;
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_fv: got %0b want 0", frame_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %0b want 0", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
        total++; if (fill_count !== 2'd0) begin bad++; $display("FAIL reset_fill: got %0d want 0", fill_count); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr: got %0b want 0", overrun); end
        total++; if (frame_data !== 64'h0) begin bad++; $display("FAIL reset_frame: got %h want 0", frame_data); end
    endtask

    task automatic test_single;
        apply_reset;
        do_start(1'b0);
        total++; if (in_ready !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL single_ready: got ready=%0b busy=%0b want 1 1", in_ready, busy); end
        feed(16'd1); feed(16'd2);
        total++; if (fill_count !== 2'd2) begin bad++; $display("FAIL single_fill: got %0d want 2", fill_count); end
        feed(16'd3);
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL single_early_fv: got %0b want 0", frame_valid); end
        feed(16'd4);
        exp64 = {16'd1, 16'd2, 16'd3, 16'd4};
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL single_fv: got %0b want 1", frame_valid); end
        total++; if (frame_data !== exp64) begin bad++; $display("FAIL single_frame: got %h want %h", frame_data, exp64); end
        total++; if (in_ready !== 1'b0 || fill_count !== 2'd0) begin bad++; $display("FAIL single_after: got ready=%0b fill=%0d want 0 0", in_ready, fill_count); end
        frame_ack = 1'b1; tick; frame_ack = 1'b0;
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL single_ack: got %0b want 0", frame_valid); end
        frame_ack = 1'b1; tick; frame_ack = 1'b0;
        total++; if (frame_valid !== 1'b0 || frame_data !== exp64) begin bad++; $display("FAIL stray_ack: got fv=%0b frame=%h want 0 %h", frame_valid, frame_data, exp64); end
    endtask

    task automatic test_gaps;
        apply_reset;
        do_start(1'b0);
        for (int i = 1; i <= 4; i++) begin
            feed(16'(i));
            d_in = 16'hDEAD;
            repeat (2) tick;
            if (i < 4) begin
                total++; if (fill_count !== 2'(i)) begin bad++; $display("FAIL gap_fill%0d: got %0d want %0d", i, fill_count, i); end
            end
        end
        exp64 = {16'd1, 16'd2, 16'd3, 16'd4};
        total++; if (frame_valid !== 1'b1 || frame_data !== exp64) begin bad++; $display("FAIL gap_frame: got fv=%0b %h want 1 %h", frame_valid, frame_data, exp64); end
    endtask

    task automatic test_cont;
        apply_reset;
        do_start(1'b1);
        feed(16'(-5)); feed(16'(-4)); feed(16'(-3)); feed(16'(-2));
        exp64 = {16'(-5), 16'(-4), 16'(-3), 16'(-2)};
        total++; if (frame_valid !== 1'b1 || frame_data !== exp64) begin bad++; $display("FAIL cont_f1: got fv=%0b %h want 1 %h", frame_valid, frame_data, exp64); end
        feed(16'(-1));
        frame_ack = 1'b1; feed(16'd0); frame_ack = 1'b0;
        total++; if (frame_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL cont_ack1: got fv=%0b busy=%0b want 0 1", frame_valid, busy); end
        feed(16'd1); feed(16'd2);
        exp64 = {16'(-1), 16'd0, 16'd1, 16'd2};
        total++; if (frame_valid !== 1'b1 || frame_data !== exp64) begin bad++; $display("FAIL cont_f2: got fv=%0b %h want 1 %h", frame_valid, frame_data, exp64); end
        total++; if (overrun !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL cont_ovr: got ovr=%0b ready=%0b want 0 1", overrun, in_ready); end
    endtask

    task automatic test_overrun;
        apply_reset;
        do_start(1'b1);
        for (int i = -5; i <= 2; i++) feed(16'(i));
        exp64 = {16'(-5), 16'(-4), 16'(-3), 16'(-2)};
        total++; if (frame_valid !== 1'b1 || frame_data !== exp64) begin bad++; $display("FAIL ovr_keep: got fv=%0b %h want 1 %h", frame_valid, frame_data, exp64); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set: got %0b want 1", overrun); end
        do_start(1'b0);
        total++; if (overrun !== 1'b0 || frame_valid !== 1'b1) begin bad++; $display("FAIL ovr_clear: got ovr=%0b fv=%0b want 0 1", overrun, frame_valid); end
    endtask

    task automatic test_back_to_back;
        apply_reset;
        do_start(1'b1);
        for (int i = 1; i <= 7; i++) feed(16'(i));
        frame_ack = 1'b1; feed(16'd8); frame_ack = 1'b0;
        exp64 = {16'd5, 16'd6, 16'd7, 16'd8};
        total++; if (frame_valid !== 1'b1 || frame_data !== exp64) begin bad++; $display("FAIL b2b_frame: got fv=%0b %h want 1 %h", frame_valid, frame_data, exp64); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_ovr: got %0b want 0", overrun); end
    endtask

    task automatic test_restart;
        apply_reset;
        do_start(1'b0);
        feed(16'd1); feed(16'd2); feed(16'd3);
        start = 1'b1; feed(16'd4); start = 1'b0;
        total++; if (frame_valid !== 1'b0 || fill_count !== 2'd0 || busy !== 1'b1) begin bad++; $display("FAIL restart_win: got fv=%0b fill=%0d busy=%0b want 0 0 1", frame_valid, fill_count, busy); end
        feed(16'd10); feed(16'd11); feed(16'd12); feed(16'd13);
        exp64 = {16'd10, 16'd11, 16'd12, 16'd13};
        total++; if (frame_valid !== 1'b1 || frame_data !== exp64) begin bad++; $display("FAIL restart_frame: got fv=%0b %h want 1 %h", frame_valid, frame_data, exp64); end
    endtask

    task automatic test_reset_mid;
        apply_reset;
        do_start(1'b0);
        feed(16'd1); feed(16'd2);
        #2 rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || in_ready !== 1'b0 || fill_count !== 2'd0 || frame_valid !== 1'b0 || overrun !== 1'b0) begin
            bad++; $display("FAIL rstmid_async: got busy=%0b ready=%0b fill=%0d fv=%0b ovr=%0b want all 0", busy, in_ready, fill_count, frame_valid, overrun); end
        tick;
        rst_n = 1'b1;
        tick;
        do_start(1'b0);
        feed(16'd5); feed(16'd6); feed(16'd7); feed(16'd8);
        exp64 = {16'd5, 16'd6, 16'd7, 16'd8};
        total++; if (frame_valid !== 1'b1 || frame_data !== exp64) begin bad++; $display("FAIL rstmid_frame: got fv=%0b %h want 1 %h", frame_valid, frame_data, exp64); end
    endtask

    task automatic test_wide;
        apply_reset;
        b_start = 1'b1; tick; b_start = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            b_valid = 1'b1; b_din = 12'(i);
            tick;
            b_valid = 1'b0;
            if (i == 31) begin
                total++; if (b_fv !== 1'b0 || b_fill !== 5'd31) begin bad++; $display("FAIL wide_31: got fv=%0b fill=%0d want 0 31", b_fv, b_fill); end
            end
        end
        for (int k = 0; k < 32; k++) exp384[k*12 +: 12] = 12'(32 - k);
        total++; if (b_fv !== 1'b1 || b_frame !== exp384) begin bad++; $display("FAIL wide_frame: got fv=%0b %h want 1 %h", b_fv, b_frame, exp384); end
        total++; if (b_ready !== 1'b0 || b_ovr !== 1'b0) begin bad++; $display("FAIL wide_after: got ready=%0b ovr=%0b want 0 0", b_ready, b_ovr); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_gaps;
        test_cont;
        test_overrun;
        test_back_to_back;
        test_restart;
        test_reset_mid;
        test_wide;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sipo_frame_buf
